eth_tx_frame_fifo: RTL
======================

Name: eth_tx_frame_fifo

Overview:
Store-and-forward transmit frame buffer that drives the 32-bit AXI-Stream TX input of the 10G MAC (s_axis_tx_*) from a user-side AXI-Stream source.
- Holds each frame until its last beat is stored, so the MAC never sees tvalid drop inside a frame; a mid-frame gap would cause the MAC to abort with an underrun.
- Drops frames marked bad (tuser on the last beat) and frames that overflow, without stalling the upstream source.
- Sits in the coreclk domain between packet-generation logic and the MAC.

Parameters:
ADDR_W, 9, buffer address width; the buffer holds 2^ADDR_W words of 36 bits (32 data + 4 keep); usable capacity is 2^ADDR_W - 1 words.

Ports:
coreclk  input  1  core clock, all logic is on its rising edge
reset  input  1  synchronous, active-high reset
s_axis_tdata  input  32  user frame data
s_axis_tkeep  input  4  byte enables; must be 4'hF except on the last beat
s_axis_tvalid  input  1  user beat valid
s_axis_tlast  input  1  last beat of the frame
s_axis_tuser  input  1  sampled on the last beat; 1 marks the frame bad, so it is dropped
s_axis_tready  output  1  fifo ready for a user beat
m_axis_tx_tdata  output  32  data to MAC s_axis_tx_tdata
m_axis_tx_tkeep  output  4  keep to MAC
m_axis_tx_tvalid  output  1  valid to MAC
m_axis_tx_tlast  output  1  last to MAC
m_axis_tx_tuser  output  1  to MAC; held at 0
m_axis_tx_tready  input  1  ready from MAC
frame_drop  output  1  one-cycle pulse when a frame is discarded
frames_stored  output  ADDR_W+1  number of complete frames committed and not yet fully sent

Behaviour:
- Reset:
  - wptr, wstart, rptr and frames_stored are set to 0.
  - Write state returns to WR_IDLE; read state returns to RD_IDLE.
  - s_axis_tready=1; all m_axis_tx_* outputs=0; frame_drop=0.
  - Reset mid-frame on either side discards all contents; m_axis_tx_tvalid is 0 in the first cycle after the reset edge.
- Write side, states WR_IDLE / WR_FRAME / WR_DROP:
  - s_axis_tready is 1 in every state; the user source is never stalled.
  - On an accepted beat in WR_IDLE or WR_FRAME: if wptr+1 == rptr (mod 2^ADDR_W), the buffer is full and the state enters WR_DROP. Otherwise {tkeep,tdata} is written at wptr and wptr increments.
  - In WR_DROP, beats are discarded until tlast.
  - On an accepted tlast beat:
    - If tuser=1 or the frame hit full: wptr returns to wstart, frame_drop pulses on the next edge, and the state goes to WR_IDLE.
    - Otherwise the frame is committed: wstart is set to wptr+1 and frames_stored increments on the same edge.
  - A single-beat frame is legal.
- Read side, states RD_IDLE / RD_FRAME:
  - In RD_IDLE, when frames_stored>0, the block issues a read at rptr.
  - The buffer read has 1-cycle latency, followed by an output register plus a 2-entry skid/prefetch.
  - m_axis_tx_tvalid rises 2 cycles after the edge that accepted the committing tlast (buffer empty beforehand).
- Inside a frame:
  - m_axis_tx_tvalid stays 1 from the first beat through the tlast beat regardless of m_axis_tx_tready.
  - Data is held stable while tready=0.
- Frame completion:
  - On acceptance of the tlast beat (tvalid & tready & tlast), frames_stored decrements.
  - At most 1 idle cycle is allowed between back-to-back frames.
- Simultaneous commit and read-completion: frames_stored is unchanged.
- Pointer wrap: pointers wrap modulo 2^ADDR_W. Full is wptr+1==rptr; empty is frames_stored==0.
- The read side never reads past wstart, so uncommitted words are never sent.

Optional Feature:
- Macro: ETH_TX_FIFO_STATS_EN.
- When defined:
  - Two extra output ports are added: tx_frame_count[31:0] and tx_drop_count[31:0].
  - tx_frame_count increments on each tlast accepted on m_axis_tx.
  - tx_drop_count increments with each frame_drop pulse.
  - Both counters reset to 0 and wrap at 2^32.
- When undefined: neither port nor counter logic exists, and all other behaviour is identical.

Test Plan:
- Single 16-beat frame (data 0..15, last tkeep=4'h3), MAC tready=1 -> m_axis_tx_tvalid rises 2 cycles after tlast accepted; 16 identical beats, contiguous tvalid, last tkeep=4'h3; frames_stored goes 1 then 0.
- Same frame with MAC tready toggling 1/0 every cycle -> tvalid never drops mid-frame; no beat duplicated or lost; data held while tready=0.
- Frame with tuser=1 on the last beat -> frame_drop pulses once; nothing appears on m_axis_tx; a following good 4-beat frame is output correctly.
- ADDR_W=4, MAC tready=0: 15-beat frame is committed (frames_stored=1); a subsequent 3-beat frame hits full -> dropped with frame_drop=1 and s_axis_tready held at 1. After tready=1, only the 15-beat frame is sent.
- 100 back-to-back random-length frames (1-40 beats) with random MAC backpressure, including pointer wrap -> output matches scoreboard in order; gap between frames is ≤1 cycle when tready=1.
- Reset asserted mid-output of a frame -> the next cycle m_axis_tx_tvalid=0, frames_stored=0, s_axis_tready=1; a later frame is sent intact. With ETH_TX_FIFO_STATS_EN, the counters read 0 after the reset.

Source files
------------

// File: rtl/eth_tx_frame_fifo.sv
// -----------------------------------------------------------------------------
// eth_tx_frame_fifo
//
// Store-and-forward transmit frame buffer between user packet logic and the
// 32-bit AXI-Stream TX input of the 10G MAC. A frame is only offered to the
// MAC once its last beat is stored, so m_axis_tx_tvalid never drops inside a
// frame. Bad frames (tuser on the last beat) and frames that overflow the
// buffer are discarded without stalling the source.
//
// Ports:
//   coreclk, reset        core clock; synchronous active-high reset
//   s_axis_*              user-side AXI-Stream sink (tready is always 1)
//   m_axis_tx_*           AXI-Stream source toward the MAC (tuser held 0)
//   frame_drop            one-cycle pulse per discarded frame
//   frames_stored         committed frames not yet fully sent
//
// Optional feature (macro ETH_TX_FIFO_STATS_EN):
//   adds tx_frame_count / tx_drop_count, 32-bit wrapping counters of frames
//   sent to the MAC and frames dropped.
//
// Buffer: 2^ADDR_W words of {tkeep, tdata}, plus a 1-bit end-of-frame
// sideband per word so the read side can find frame boundaries.
// -----------------------------------------------------------------------------
module eth_tx_frame_fifo #(
    parameter int ADDR_W = 9
) (
    input  logic              coreclk,
    input  logic              reset,
    input  logic [31:0]       s_axis_tdata,
    input  logic [3:0]        s_axis_tkeep,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tuser,
    output logic              s_axis_tready,
    output logic [31:0]       m_axis_tx_tdata,
    output logic [3:0]        m_axis_tx_tkeep,
    output logic              m_axis_tx_tvalid,
    output logic              m_axis_tx_tlast,
    output logic              m_axis_tx_tuser,
    input  logic              m_axis_tx_tready,
    output logic              frame_drop,
    output logic [ADDR_W:0]   frames_stored
`ifdef ETH_TX_FIFO_STATS_EN
    ,
    output logic [31:0]       tx_frame_count,
    output logic [31:0]       tx_drop_count
`endif
);

    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] WR_IDLE  = 2'd0;
    localparam logic [1:0] WR_FRAME = 2'd1;
    localparam logic [1:0] WR_DROP  = 2'd2;

    localparam logic [0:0] RD_IDLE  = 1'b0;
    localparam logic [0:0] RD_FRAME = 1'b1;

    // ---------------------------------------------------------------- storage
    logic [35:0] data_mem [DEPTH];
    logic        last_mem [DEPTH];

    // ------------------------------------------------------------ write side
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [ADDR_W-1:0] wstart_q, wstart_d;
    logic [1:0]        wr_state_q, wr_state_d;
    logic              frame_drop_q, frame_drop_d;
    logic [ADDR_W-1:0] wptr_inc;
    logic              full;
    logic              wr_ok;
    logic              mem_we;
    logic              commit;

    // ------------------------------------------------------------- read side
    logic [ADDR_W-1:0] rptr_q, rptr_d;
    logic [0:0]        rd_state_q, rd_state_d;
    logic              rd_valid_q, rd_valid_d;
    logic [35:0]       rd_word_q;
    logic              rd_last_q;
    logic              rd_en;
    logic              have_data;
    logic              room;
    logic [1:0]        occ;

    // Two-entry skid; entry 0 is the head and drives the MAC outputs directly.
    logic [1:0][36:0]  skid_q, skid_d;
    logic [1:0]        skid_cnt_q, skid_cnt_d;
    logic              pop;
    logic              tx_done;

    logic [ADDR_W:0]   frames_q, frames_d;

    assign wptr_inc = wptr_q + PTR_ONE;
    // One slot is sacrificed so that wptr == rptr can only mean "nothing
    // between them", never "completely full".
    assign full     = (wptr_inc == rptr_q);
    assign wr_ok    = (wr_state_q != WR_DROP) && !full;

    // NOTE: every signal written in an always_comb gets a default first, so a
    // missed branch holds the flop value instead of inferring a latch.
    always_comb begin
        wptr_d       = wptr_q;
        wstart_d     = wstart_q;
        wr_state_d   = wr_state_q;
        frame_drop_d = 1'b0;
        mem_we       = 1'b0;
        commit       = 1'b0;
        if (s_axis_tvalid) begin
            if (wr_ok) begin
                mem_we = 1'b1;
                wptr_d = wptr_inc;
            end
            if (s_axis_tlast) begin
                if (!wr_ok || s_axis_tuser) begin
                    // Rewind over the partial frame; it was never visible to
                    // the read side because wstart did not move.
                    wptr_d       = wstart_q;
                    frame_drop_d = 1'b1;
                end else begin
                    wstart_d = wptr_inc;
                    commit   = 1'b1;
                end
                wr_state_d = WR_IDLE;
            end else if (!wr_ok) begin
                wr_state_d = WR_DROP;
            end else begin
                wr_state_d = WR_FRAME;
            end
        end
    end

    // Read issue: fetch only committed words (rptr stops at wstart) and only
    // when the skid will have space for the word once it arrives next cycle.
    assign pop       = m_axis_tx_tvalid && m_axis_tx_tready;
    assign tx_done   = pop && skid_q[0][36];
    assign occ       = skid_cnt_q + {1'b0, rd_valid_q};
    assign room      = (occ < 2'd2) || ((occ == 2'd2) && pop);
    assign have_data = (rptr_q != wstart_q);
    assign rd_en     = room && have_data;

    always_comb begin
        rptr_d     = rptr_q;
        rd_state_d = rd_state_q;
        rd_valid_d = rd_en;
        if (rd_en) begin
            rptr_d     = rptr_q + PTR_ONE;
            rd_state_d = RD_FRAME;
        end else if (rd_valid_q && rd_last_q) begin
            rd_state_d = RD_IDLE;
        end
    end

    always_comb begin
        skid_d     = skid_q;
        skid_cnt_d = skid_cnt_q;
        case ({rd_valid_q, pop})
            2'b01: begin
                skid_d[0]  = skid_q[1];
                skid_cnt_d = skid_cnt_q - 2'd1;
            end
            2'b10: begin
                skid_d[skid_cnt_q[0]] = {rd_last_q, rd_word_q};
                skid_cnt_d            = skid_cnt_q + 2'd1;
            end
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    skid_d[0] = {rd_last_q, rd_word_q};
                end else begin
                    skid_d[0] = skid_q[1];
                    skid_d[1] = {rd_last_q, rd_word_q};
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        frames_d = frames_q;
        case ({commit, tx_done})
            2'b10:   frames_d = frames_q + 1'b1;
            2'b01:   frames_d = frames_q - 1'b1;
            default: ;
        endcase
    end

    // NOTE: the buffer array has no reset; pointers define which words are
    // meaningful, and a reset array could not map onto block RAM.
    always_ff @(posedge coreclk) begin
        if (mem_we) begin
            data_mem[wptr_q] <= {s_axis_tkeep, s_axis_tdata};
            last_mem[wptr_q] <= s_axis_tlast;
        end
        if (rd_en) begin
            rd_word_q <= data_mem[rptr_q];
            rd_last_q <= last_mem[rptr_q];
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge coreclk) begin
        if (reset) begin
            wptr_q       <= '0;
            wstart_q     <= '0;
            wr_state_q   <= WR_IDLE;
            frame_drop_q <= 1'b0;
            rptr_q       <= '0;
            rd_state_q   <= RD_IDLE;
            rd_valid_q   <= 1'b0;
            skid_q       <= '0;
            skid_cnt_q   <= '0;
            frames_q     <= '0;
        end else begin
            wptr_q       <= wptr_d;
            wstart_q     <= wstart_d;
            wr_state_q   <= wr_state_d;
            frame_drop_q <= frame_drop_d;
            rptr_q       <= rptr_d;
            rd_state_q   <= rd_state_d;
            rd_valid_q   <= rd_valid_d;
            skid_q       <= skid_d;
            skid_cnt_q   <= skid_cnt_d;
            frames_q     <= frames_d;
        end
    end

    assign s_axis_tready    = 1'b1;
    assign m_axis_tx_tvalid = (skid_cnt_q != 2'd0);
    assign m_axis_tx_tdata  = skid_q[0][31:0];
    assign m_axis_tx_tkeep  = skid_q[0][35:32];
    assign m_axis_tx_tlast  = skid_q[0][36];
    assign m_axis_tx_tuser  = 1'b0;
    assign frame_drop       = frame_drop_q;
    assign frames_stored    = frames_q;

`ifdef ETH_TX_FIFO_STATS_EN
    logic [31:0] tx_frame_count_q, tx_frame_count_d;
    logic [31:0] tx_drop_count_q, tx_drop_count_d;

    always_comb begin
        tx_frame_count_d = tx_frame_count_q + {31'd0, tx_done};
        tx_drop_count_d  = tx_drop_count_q + {31'd0, frame_drop_d};
    end

    always_ff @(posedge coreclk) begin
        if (reset) begin
            tx_frame_count_q <= '0;
            tx_drop_count_q  <= '0;
        end else begin
            tx_frame_count_q <= tx_frame_count_d;
            tx_drop_count_q  <= tx_drop_count_d;
        end
    end

    assign tx_frame_count = tx_frame_count_q;
    assign tx_drop_count  = tx_drop_count_q;
`endif

endmodule
